mcpu_ctrl_fsm: RTL and testbench

- Multi-cycle MIPS control unit that sequences the multi-cycle datapath.
- Each instruction runs through fetch / decode / execute / memory / writeback states.
- Generates every datapath control strobe plus memory-bus requests, and stalls on MIO_ready during memory phases.
- Flags illegal opcodes and suppresses register writeback on arithmetic overflow.

---
 rtl/mcpu_ctrl_fsm.sv | 192 +++++++++++++++++++
 tb/tb_mcpu_ctrl_fsm.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcpu_ctrl_fsm.sv
// Multi-cycle MIPS control unit: sequences fetch/decode/execute/memory/writeback.
// Outputs are registered from the next state and the IR, so they line up with the state register.
module mcpu_ctrl_fsm #(
  parameter int         ST_W    = 5,
  parameter logic [2:0] ALU_ADD = 3'b010
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     Inst,
  input  logic            zero,
  input  logic            overflow,
  input  logic            MIO_ready,
  output logic            IorD,
  output logic            IRWrite,
  output logic            RegWrite,
  output logic            ALUSrcA,
  output logic            PCWrite,
  output logic            PCWriteCond,
  output logic            Branch,
  output logic            shift,
  output logic            unsign,
  output logic [1:0]      RegDst,
  output logic [1:0]      MemtoReg,
  output logic [1:0]      ALUSrcB,
  output logic [1:0]      PCSource,
  output logic [2:0]      ALU_operation,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            CPU_MIO,
  output logic            illegal,
  output logic [ST_W-1:0] state
);

  localparam logic [2:0] ALU_AND = 3'b000, ALU_OR  = 3'b001, ALU_XOR = 3'b011,
                         ALU_NOR = 3'b100, ALU_SRL = 3'b101, ALU_SUB = 3'b110,
                         ALU_SLT = 3'b111;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_J = 6'b000010,
                         OP_JAL = 6'b000011, OP_ADDI = 6'b001000, OP_ANDI = 6'b001100,
                         OP_ORI = 6'b001101, OP_XORI = 6'b001110, OP_SLTI = 6'b001010,
                         OP_LUI = 6'b001111;

  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100,
                         F_OR  = 6'b100101, F_XOR = 6'b100110, F_NOR = 6'b100111,
                         F_SLT = 6'b101010, F_SRL = 6'b000010, F_JR  = 6'b001000;

  typedef enum logic [ST_W-1:0] {
    S_IF, S_ID, S_EX_R, S_R_WB, S_EX_I, S_I_WB, S_MA, S_MRD,
    S_MWB, S_MWR, S_BR, S_JMP, S_JAL, S_JR, S_LUI, S_ERR
  } state_t;

  typedef struct packed {
    logic       iord, irwrite, regwrite, alusrca, pcwrite, pcwritecond, branch, shift, unsign;
    logic [1:0] regdst, memtoreg, alusrcb, pcsource;
    logic [2:0] alu_op;
    logic       memread, memwrite, cpu_mio, illegal;
  } ctl_t;

  state_t st, nxt;
  logic   ovf_q, ovf_nxt;
  ctl_t   ctl_q;
  logic   unused_in;

  wire [5:0] op = Inst[31:26];
  wire [5:0] fn = Inst[5:0];

  // zero is consumed by the datapath's PCWriteCond gating, not here
  assign unused_in = ^{zero, Inst[25:6]};

  function automatic logic r_known(input logic [5:0] f);
    return f inside {F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SRL};
  endfunction

  function automatic logic [2:0] r_alu(input logic [5:0] f);
    case (f)
      F_ADD:   return ALU_ADD;
      F_SUB:   return ALU_SUB;
      F_OR:    return ALU_OR;
      F_XOR:   return ALU_XOR;
      F_NOR:   return ALU_NOR;
      F_SLT:   return ALU_SLT;
      F_SRL:   return ALU_SRL;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic logic [2:0] i_alu(input logic [5:0] o);
    case (o)
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      OP_XORI: return ALU_XOR;
      OP_SLTI: return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

  function automatic ctl_t decode(input state_t s, input logic [31:0] ins, input logic ovf);
    ctl_t c;
    c = '0;
    case (s)
      S_IF:   begin c.memread = 1'b1; c.cpu_mio = 1'b1; c.irwrite = 1'b1;
                    c.alusrcb = 2'b01; c.alu_op = ALU_ADD; c.pcwrite = 1'b1; end
      S_ID:   begin c.alusrcb = 2'b11; c.alu_op = ALU_ADD; end
      S_EX_R: begin c.alusrca = 1'b1; c.alu_op = r_alu(ins[5:0]);
                    c.shift = (ins[5:0] == F_SRL); end
      S_R_WB: begin c.regdst = 2'b01; c.regwrite = ~ovf; end
      S_EX_I: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; c.alu_op = i_alu(ins[31:26]);
                    c.unsign = ins[31:26] inside {OP_ANDI, OP_ORI, OP_XORI}; end
      S_I_WB: c.regwrite = ~ovf;
      S_MA:   begin c.alusrca = 1'b1; c.alusrcb = 2'b10; c.alu_op = ALU_ADD; end
      S_MRD:  begin c.iord = 1'b1; c.memread = 1'b1; c.cpu_mio = 1'b1; end
      S_MWB:  begin c.memtoreg = 2'b01; c.regwrite = 1'b1; end
      S_MWR:  begin c.iord = 1'b1; c.memwrite = 1'b1; c.cpu_mio = 1'b1; end
      S_BR:   begin c.alusrca = 1'b1; c.alu_op = ALU_SUB; c.pcwritecond = 1'b1;
                    c.pcsource = 2'b01; c.branch = (ins[31:26] == OP_BEQ); end
      S_JMP:  begin c.pcsource = 2'b10; c.pcwrite = 1'b1; end
      S_JAL:  begin c.pcsource = 2'b10; c.pcwrite = 1'b1; c.regdst = 2'b10;
                    c.memtoreg = 2'b11; c.regwrite = 1'b1; end
      S_JR:   begin c.pcsource = 2'b11; c.pcwrite = 1'b1; end
      S_LUI:  begin c.memtoreg = 2'b10; c.regwrite = 1'b1; end
      S_ERR:  c.illegal = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  always_comb begin
    nxt     = S_IF;
    ovf_nxt = ovf_q;
    case (st)
      S_IF:   nxt = MIO_ready ? S_ID : S_IF;
      S_ID: begin
        case (op)
          OP_R:                                     nxt = (fn == F_JR) ? S_JR : S_EX_R;
          OP_LW, OP_SW:                             nxt = S_MA;
          OP_BEQ, OP_BNE:                           nxt = S_BR;
          OP_J:                                     nxt = S_JMP;
          OP_JAL:                                   nxt = S_JAL;
          OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: nxt = S_EX_I;
          OP_LUI:                                   nxt = S_LUI;
          default:                                  nxt = S_ERR;
        endcase
      end
      S_EX_R: begin
        nxt     = r_known(fn) ? S_R_WB : S_ERR;
        ovf_nxt = overflow & ((fn == F_ADD) | (fn == F_SUB));
      end
      S_EX_I: begin
        nxt     = S_I_WB;
        ovf_nxt = overflow & (op == OP_ADDI);
      end
      S_MA:   nxt = (op == OP_SW) ? S_MWR : S_MRD;
      S_MRD:  nxt = MIO_ready ? S_MWB : S_MRD;
      S_MWR:  nxt = MIO_ready ? S_IF : S_MWR;
      default: nxt = S_IF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      st    <= S_IF;
      ovf_q <= 1'b0;
      ctl_q <= decode(S_IF, Inst, 1'b0);
    end else begin
      st    <= nxt;
      ovf_q <= ovf_nxt;
      ctl_q <= decode(nxt, Inst, ovf_nxt);
    end
  end

  assign IorD          = ctl_q.iord;
  assign IRWrite       = ctl_q.irwrite;
  assign RegWrite      = ctl_q.regwrite;
  assign ALUSrcA       = ctl_q.alusrca;
  assign PCWrite       = ctl_q.pcwrite;
  assign PCWriteCond   = ctl_q.pcwritecond;
  assign Branch        = ctl_q.branch;
  assign shift         = ctl_q.shift;
  assign unsign        = ctl_q.unsign;
  assign RegDst        = ctl_q.regdst;
  assign MemtoReg      = ctl_q.memtoreg;
  assign ALUSrcB       = ctl_q.alusrcb;
  assign PCSource      = ctl_q.pcsource;
  assign ALU_operation = ctl_q.alu_op;
  assign MemRead       = ctl_q.memread;
  assign MemWrite      = ctl_q.memwrite;
  assign CPU_MIO       = ctl_q.cpu_mio;
  assign illegal       = ctl_q.illegal;
  assign state         = st;

endmodule

// File: tb/tb_mcpu_ctrl_fsm.sv
// Bench for mcpu_ctrl_fsm: fixed vector table, hand sequences, then random instructions vs a phase-list model.
module tb_mcpu_ctrl_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, zero, overflow, MIO_ready;
  logic [31:0] Inst;
  logic        IorD, IRWrite, RegWrite, ALUSrcA, PCWrite, PCWriteCond, Branch, shift, unsign;
  logic [1:0]  RegDst, MemtoReg, ALUSrcB, PCSource;
  logic [2:0]  ALU_operation;
  logic        MemRead, MemWrite, CPU_MIO, illegal;
  logic [4:0]  state;

  mcpu_ctrl_fsm dut (
    .clk(clk), .reset(reset), .Inst(Inst), .zero(zero), .overflow(overflow),
    .MIO_ready(MIO_ready), .IorD(IorD), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .Branch(Branch),
    .shift(shift), .unsign(unsign), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALU_operation(ALU_operation),
    .MemRead(MemRead), .MemWrite(MemWrite), .CPU_MIO(CPU_MIO), .illegal(illegal),
    .state(state)
  );

  typedef struct packed {
    logic       iord, irwrite, regwrite, alusrca, pcwrite, pcwritecond, branch, shift, unsign;
    logic [1:0] regdst, memtoreg, alusrcb, pcsource;
    logic [2:0] aluop;
    logic       memread, memwrite, cpu_mio, illegal;
  } ctl_t;

  ctl_t act;
  assign act = {IorD, IRWrite, RegWrite, ALUSrcA, PCWrite, PCWriteCond, Branch, shift, unsign,
                RegDst, MemtoReg, ALUSrcB, PCSource, ALU_operation,
                MemRead, MemWrite, CPU_MIO, illegal};

  localparam int P_IF = 0, P_ID = 1, P_EXR = 2, P_RWB = 3, P_EXI = 4, P_IWB = 5, P_MA = 6,
                 P_MRD = 7, P_MWB = 8, P_MWR = 9, P_BR = 10, P_JMP = 11, P_JAL = 12,
                 P_JR = 13, P_LUI = 14, P_ERR = 15;

  int   n_cmp = 0, n_bad = 0;
  int   plan_q[$];
  logic ovf_m;

  function automatic logic [2:0] funct_op(input logic [5:0] f);
    case (f)
      6'h20: return 3'b010;  6'h22: return 3'b110;
      6'h24: return 3'b000;  6'h25: return 3'b001;
      6'h26: return 3'b011;  6'h27: return 3'b100;
      6'h2A: return 3'b111;  6'h02: return 3'b101;
      default: return 3'b000;
    endcase
  endfunction

  function automatic ctl_t exp_ctl(input int ph, input logic [31:0] ins, input logic ovf);
    ctl_t c;
    logic [5:0] op, fn;
    c = '0; op = ins[31:26]; fn = ins[5:0];
    case (ph)
      P_IF:  begin c.memread = 1; c.cpu_mio = 1; c.irwrite = 1; c.alusrcb = 2'b01;
                   c.aluop = 3'b010; c.pcwrite = 1; end
      P_ID:  begin c.alusrcb = 2'b11; c.aluop = 3'b010; end
      P_EXR: begin c.alusrca = 1; c.aluop = funct_op(fn); c.shift = (fn == 6'h02); end
      P_RWB: begin c.regdst = 2'b01; c.regwrite = !ovf; end
      P_EXI: begin
        c.alusrca = 1; c.alusrcb = 2'b10;
        case (op)
          6'h0C: c.aluop = 3'b000;  6'h0D: c.aluop = 3'b001;
          6'h0E: c.aluop = 3'b011;  6'h0A: c.aluop = 3'b111;
          default: c.aluop = 3'b010;
        endcase
        c.unsign = (op == 6'h0C) || (op == 6'h0D) || (op == 6'h0E);
      end
      P_IWB: c.regwrite = !ovf;
      P_MA:  begin c.alusrca = 1; c.alusrcb = 2'b10; c.aluop = 3'b010; end
      P_MRD: begin c.iord = 1; c.memread = 1; c.cpu_mio = 1; end
      P_MWB: begin c.memtoreg = 2'b01; c.regwrite = 1; end
      P_MWR: begin c.iord = 1; c.memwrite = 1; c.cpu_mio = 1; end
      P_BR:  begin c.alusrca = 1; c.aluop = 3'b110; c.pcwritecond = 1; c.pcsource = 2'b01;
                   c.branch = (op == 6'h04); end
      P_JMP: begin c.pcsource = 2'b10; c.pcwrite = 1; end
      P_JAL: begin c.pcsource = 2'b10; c.pcwrite = 1; c.regdst = 2'b10; c.memtoreg = 2'b11;
                   c.regwrite = 1; end
      P_JR:  begin c.pcsource = 2'b11; c.pcwrite = 1; end
      P_LUI: begin c.memtoreg = 2'b10; c.regwrite = 1; end
      default: c.illegal = 1;
    endcase
    return c;
  endfunction

  // Sequence of phases an instruction walks through, straight from the opcode/funct rules
  task automatic plan(input logic [31:0] ins);
    logic [5:0] op, fn;
    op = ins[31:26]; fn = ins[5:0];
    plan_q = {P_IF, P_ID};
    case (op)
      6'h00: begin
        if (fn == 6'h08) plan_q.push_back(P_JR);
        else begin
          plan_q.push_back(P_EXR);
          if (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h02})
            plan_q.push_back(P_RWB);
          else plan_q.push_back(P_ERR);
        end
      end
      6'h23: plan_q = {plan_q, P_MA, P_MRD, P_MWB};
      6'h2B: plan_q = {plan_q, P_MA, P_MWR};
      6'h04, 6'h05: plan_q.push_back(P_BR);
      6'h02: plan_q.push_back(P_JMP);
      6'h03: plan_q.push_back(P_JAL);
      6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0A: plan_q = {plan_q, P_EXI, P_IWB};
      6'h0F: plan_q.push_back(P_LUI);
      default: plan_q.push_back(P_ERR);
    endcase
  endtask

  task automatic check(input string nm, input ctl_t a, input ctl_t e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h required %h (t=%0t)", nm, a, e, $time);
    end
  endtask

  task automatic check_int(input string nm, input int a, input int e);
    n_cmp++;
    if (a != e) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", nm, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Walk one instruction from IF back to IF, comparing every cycle against the model
  task automatic run_inst(input logic [31:0] ins, input bit rnd, input int stall_n);
    int p, waits;
    plan(ins);
    Inst  = ins;
    ovf_m = 1'b0;
    foreach (plan_q[i]) begin
      p = plan_q[i];
      waits = 0;
      forever begin
        if (rnd) begin
          MIO_ready = ($urandom_range(3) != 0);
          overflow  = $urandom_range(1);
        end else begin
          MIO_ready = !((p == P_MRD || p == P_MWR) && waits < stall_n);
          overflow  = 1'b0;
        end
        #1;
        check($sformatf("ph%0d_inst%h", p, ins), act, exp_ctl(p, ins, ovf_m));
        if (p == P_EXR) ovf_m = overflow && (ins[5:0] == 6'h20 || ins[5:0] == 6'h22);
        if (p == P_EXI) ovf_m = overflow && (ins[31:26] == 6'h08);
        tick();
        if (!(p == P_IF || p == P_MRD || p == P_MWR) || MIO_ready) break;
        waits++;
        if (waits > 64) begin
          n_cmp++; n_bad++;
          $display("FAIL stall_bound: phase %0d never released", p);
          break;
        end
      end
    end
  endtask

  typedef struct {
    logic [31:0] inst;
    logic        ovf_in;
    int          cyc;
    int          last_ph;
    logic        wb_blocked;
  } vec_t;

  vec_t tbl[15];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n;
    ctl_t       last;
    logic [31:0] r, ins;
    logic [5:0]  fl[10];
    logic [5:0]  ol[16];

    tbl[0]  = '{32'h00221820, 1'b0, 4, P_RWB, 1'b0};   // add
    tbl[1]  = '{32'h00221820, 1'b1, 4, P_RWB, 1'b1};   // add, overflow
    tbl[2]  = '{32'h00221822, 1'b1, 4, P_RWB, 1'b1};   // sub, overflow
    tbl[3]  = '{32'h00221824, 1'b1, 4, P_RWB, 1'b0};   // and ignores overflow
    tbl[4]  = '{32'h8C220004, 1'b0, 5, P_MWB, 1'b0};   // lw
    tbl[5]  = '{32'hAC220004, 1'b0, 4, P_MWR, 1'b0};   // sw
    tbl[6]  = '{32'h10220003, 1'b0, 3, P_BR,  1'b0};   // beq
    tbl[7]  = '{32'h14220003, 1'b0, 3, P_BR,  1'b0};   // bne
    tbl[8]  = '{32'h08000010, 1'b0, 3, P_JMP, 1'b0};   // j
    tbl[9]  = '{32'h0C000010, 1'b0, 3, P_JAL, 1'b0};   // jal
    tbl[10] = '{32'h03E00008, 1'b0, 3, P_JR,  1'b0};   // jr
    tbl[11] = '{32'h3C051234, 1'b0, 3, P_LUI, 1'b0};   // lui
    tbl[12] = '{32'h20220005, 1'b1, 4, P_IWB, 1'b1};   // addi, overflow
    tbl[13] = '{32'h34220005, 1'b1, 4, P_IWB, 1'b0};   // ori ignores overflow
    tbl[14] = '{32'hFC000000, 1'b0, 3, P_ERR, 1'b0};   // illegal opcode

    fl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h02, 6'h08, 6'h3F};
    ol = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02,
           6'h03, 6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0A, 6'h0F, 6'h3F};

    reset = 1'b0; zero = 1'b0; overflow = 1'b0; MIO_ready = 1'b1; Inst = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1 check("reset_if", act, exp_ctl(P_IF, 32'h0, 1'b0));

    foreach (tbl[i]) begin
      Inst = tbl[i].inst; overflow = tbl[i].ovf_in; MIO_ready = 1'b1;
      n = 0;
      #1 check($sformatf("tbl%0d_if", i), act, exp_ctl(P_IF, tbl[i].inst, 1'b0));
      do begin
        last = act;
        n++;
        tick();
        #1;
      end while (!act.irwrite && n < 12);
      check_int($sformatf("tbl%0d_cycles", i), n, tbl[i].cyc);
      check($sformatf("tbl%0d_last", i), last,
            exp_ctl(tbl[i].last_ph, tbl[i].inst, tbl[i].wb_blocked));
    end
    #1 check("after_err_if", act, exp_ctl(P_IF, 32'h0, 1'b0));
    overflow = 1'b0;

    run_inst(32'h8C220004, 1'b0, 3);    // lw with three stalled MRD cycles
    run_inst(32'hAC220004, 1'b0, 2);    // sw with two stalled MWR cycles

    // Reset while stalled in MWR abandons the store
    Inst = 32'hAC220004; MIO_ready = 1'b1;
    repeat (3) tick();
    MIO_ready = 1'b0;
    #1 check("mwr_stall0", act, exp_ctl(P_MWR, Inst, 1'b0));
    tick();
    #1 check("mwr_stall1", act, exp_ctl(P_MWR, Inst, 1'b0));
    reset = 1'b0;
    tick();
    #1 check("rst_in_mwr", act, exp_ctl(P_IF, Inst, 1'b0));
    reset = 1'b1; MIO_ready = 1'b1;

    for (int k = 0; k < 300; k++) begin
      r   = $urandom();
      ins = r;
      ins[31:26] = ol[$urandom_range(15)];
      if (ins[31:26] == 6'h3F) ins[31:26] = 6'($urandom_range(63));
      if (ins[31:26] == 6'h00) ins[5:0] = fl[$urandom_range(9)];
      run_inst(ins, 1'b1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
